// File: rtl/tile_seq_pkg.sv
// Shared types and default geometry for the conv tile sequencer.
package tile_seq_pkg;

    localparam int ADDR_W_DEF     = 32;
    localparam int CNT_W_DEF      = 16;
    localparam int IN_STRIDE_DEF  = 256;
    localparam int OUT_STRIDE_DEF = 64;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WGT   = 3'd1,
        DATA  = 3'd2,
        ADD   = 3'd3,
        WRITE = 3'd4,
        NEXT  = 3'd5,
        FIN   = 3'd6
    } seq_state_t;

endpackage

// File: rtl/tile_addr_gen.sv
// Tile counter, last-tile flag and input/output address accumulators.
module tile_addr_gen
    import tile_seq_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int CNT_W      = CNT_W_DEF,
    parameter int IN_STRIDE  = IN_STRIDE_DEF,
    parameter int OUT_STRIDE = OUT_STRIDE_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              load_i,
    input  logic              step_i,
    input  logic              clear_i,
    input  logic [CNT_W-1:0]  num_tiles_i,
    input  logic [ADDR_W-1:0] in_base_i,
    input  logic [ADDR_W-1:0] out_base_i,
    output logic [CNT_W-1:0]  tile_idx_o,
    output logic              is_last_o,
    output logic [ADDR_W-1:0] in_addr_o,
    output logic [ADDR_W-1:0] out_addr_o
);

    logic [CNT_W-1:0]  num_q, num_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] in_q, in_d;
    logic [ADDR_W-1:0] out_q, out_d;

    always_comb begin
        num_d  = num_q;
        idx_d  = idx_q;
        last_d = last_q;
        in_d   = in_q;
        out_d  = out_q;
        if (clear_i) begin
            num_d  = '0;
            idx_d  = '0;
            last_d = 1'b0;
            in_d   = '0;
            out_d  = '0;
        end else if (load_i) begin
            num_d  = num_tiles_i;
            idx_d  = '0;
            last_d = (num_tiles_i == CNT_W'(1));
            in_d   = in_base_i;
            out_d  = out_base_i;
        end else if (step_i) begin
            // Compare against the stepped index so is_last tracks tile_idx in the same cycle.
            idx_d  = idx_q + CNT_W'(1);
            last_d = (idx_d == num_q - CNT_W'(1));
            in_d   = in_q + ADDR_W'(IN_STRIDE);
            out_d  = out_q + ADDR_W'(OUT_STRIDE);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            num_q  <= '0;
            idx_q  <= '0;
            last_q <= 1'b0;
            in_q   <= '0;
            out_q  <= '0;
        end else begin
            num_q  <= num_d;
            idx_q  <= idx_d;
            last_q <= last_d;
            in_q   <= in_d;
            out_q  <= out_d;
        end
    end

    assign tile_idx_o = idx_q;
    assign is_last_o  = last_q;
    assign in_addr_o  = in_q;
    assign out_addr_o = out_q;

endmodule

// File: rtl/tile_sequencer.sv
// Job sequencer: one weight load, then per tile data load/exec, adder run and write-back.
module tile_sequencer
    import tile_seq_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int CNT_W      = CNT_W_DEF,
    parameter int IN_STRIDE  = IN_STRIDE_DEF,
    parameter int OUT_STRIDE = OUT_STRIDE_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [CNT_W-1:0]  cfg_num_tiles,
    input  logic [ADDR_W-1:0] cfg_wgt_addr,
    input  logic [ADDR_W-1:0] cfg_in_addr,
    input  logic [ADDR_W-1:0] cfg_out_addr,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              wgt_req,
    output logic [ADDR_W-1:0] wgt_addr,
    input  logic              wgt_done,
    output logic              data_req,
    output logic [ADDR_W-1:0] data_addr,
    input  logic              data_done,
    output logic              add_en,
    input  logic              add_done,
    output logic              wr_req,
    output logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_done,
    output logic [CNT_W-1:0]  tile_idx,
    output logic              is_last,
    output logic [2:0]        dbg_state
);

    seq_state_t state_q;
    logic       load, step, finish;

    assign load   = (state_q == IDLE) && start && (cfg_num_tiles != '0);
    assign step   = (state_q == NEXT) && !is_last;
    assign finish = (state_q == NEXT) && is_last;

    tile_addr_gen #(
        .ADDR_W    (ADDR_W),
        .CNT_W     (CNT_W),
        .IN_STRIDE (IN_STRIDE),
        .OUT_STRIDE(OUT_STRIDE)
    ) u_addr_gen (
        .clk        (clk),
        .rstn       (rstn),
        .load_i     (load),
        .step_i     (step),
        .clear_i    (finish),
        .num_tiles_i(cfg_num_tiles),
        .in_base_i  (cfg_in_addr),
        .out_base_i (cfg_out_addr),
        .tile_idx_o (tile_idx),
        .is_last_o  (is_last),
        .in_addr_o  (data_addr),
        .out_addr_o (wr_addr)
    );

    // Handshake: each request is a level held until its unit returns a 1-cycle done; the
    // request drops on the next edge, and the following request rises one cycle after that.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            wgt_req  <= 1'b0;
            wgt_addr <= '0;
            data_req <= 1'b0;
            add_en   <= 1'b0;
            wr_req   <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && cfg_num_tiles == '0) begin
                        err <= 1'b1;
                    end else if (start) begin
                        busy     <= 1'b1;
                        wgt_req  <= 1'b1;
                        wgt_addr <= cfg_wgt_addr;
                        state_q  <= WGT;
                    end
                end
                WGT: begin
                    if (wgt_done) begin
                        wgt_req <= 1'b0;
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (!data_req) begin
                        data_req <= 1'b1;
                    end else if (data_done) begin
                        data_req <= 1'b0;
                        state_q  <= ADD;
                    end
                end
                ADD: begin
                    if (!add_en) begin
                        add_en <= 1'b1;
                    end else if (add_done) begin
                        add_en  <= 1'b0;
                        state_q <= WRITE;
                    end
                end
                WRITE: begin
                    if (!wr_req) begin
                        wr_req <= 1'b1;
                    end else if (wr_done) begin
                        wr_req  <= 1'b0;
                        state_q <= NEXT;
                    end
                end
                NEXT: begin
                    if (is_last) begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= FIN;
                    end else begin
                        state_q <= DATA;
                    end
                end
                FIN:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_tile_sequencer.sv
// Directed bench for tile_sequencer with a cycle-stepped unit responder and event logs.
module tb_tile_sequencer;

    localparam int AW = 32;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] cfg_num_tiles = '0;
    logic [AW-1:0] cfg_wgt_addr = '0;
    logic [AW-1:0] cfg_in_addr = '0;
    logic [AW-1:0] cfg_out_addr = '0;
    logic          busy, done, err;
    logic          wgt_req, data_req, add_en, wr_req;
    logic [AW-1:0] wgt_addr, data_addr, wr_addr;
    logic          wgt_done = 1'b0, data_done = 1'b0, add_done = 1'b0, wr_done = 1'b0;
    logic [CW-1:0] tile_idx;
    logic          is_last;
    logic [2:0]    dbg_state;

    tile_sequencer dut (
        .clk          (clk),
        .rstn         (rstn),
        .start        (start),
        .cfg_num_tiles(cfg_num_tiles),
        .cfg_wgt_addr (cfg_wgt_addr),
        .cfg_in_addr  (cfg_in_addr),
        .cfg_out_addr (cfg_out_addr),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .wgt_req      (wgt_req),
        .wgt_addr     (wgt_addr),
        .wgt_done     (wgt_done),
        .data_req     (data_req),
        .data_addr    (data_addr),
        .data_done    (data_done),
        .add_en       (add_en),
        .add_done     (add_done),
        .wr_req       (wr_req),
        .wr_addr      (wr_addr),
        .wr_done      (wr_done),
        .tile_idx     (tile_idx),
        .is_last      (is_last),
        .dbg_state    (dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int lat = 0;
    bit spur_en = 1'b0;
    int cnt[4];
    bit acked[4];
    bit prev[4];
    int hi_len[4];
    int s_idx;
    int done_cnt, err_cnt, overlap_cnt, done_busy_cnt, req_rises;
    logic [AW-1:0] wgt_log[$];
    logic [AW-1:0] data_log[$];
    logic [AW-1:0] wr_log[$];
    logic [CW:0]   tile_log[$];
    int            len_log[$];
    logic [AW-1:0] exp_q[$];

    task automatic reset_model();
        for (int u = 0; u < 4; u++) begin
            cnt[u] = 0; acked[u] = 1'b0; prev[u] = 1'b0; hi_len[u] = 0;
        end
        wgt_done = 1'b0; data_done = 1'b0; add_done = 1'b0; wr_done = 1'b0;
    endtask

    task automatic clear_logs();
        wgt_log.delete(); data_log.delete(); wr_log.delete(); tile_log.delete(); len_log.delete();
        done_cnt = 0; err_cnt = 0; overlap_cnt = 0; done_busy_cnt = 0; req_rises = 0;
    endtask

    // One clock: sample outputs 1ns after the edge, log events, then drive unit done pulses.
    task automatic step_cycle();
        logic [3:0] r;
        @(posedge clk);
        #1;
        s_idx++;
        wgt_done = 1'b0; data_done = 1'b0; add_done = 1'b0; wr_done = 1'b0;
        r = {wr_req, add_en, data_req, wgt_req};
        if ($countones(r) > 1) overlap_cnt++;
        if (done) begin
            done_cnt++;
            if (busy) done_busy_cnt++;
        end
        if (err) err_cnt++;
        for (int u = 0; u < 4; u++) begin
            if (r[u] && !prev[u]) begin
                req_rises++;
                case (u)
                    0: wgt_log.push_back(wgt_addr);
                    1: begin
                        data_log.push_back(data_addr);
                        tile_log.push_back({is_last, tile_idx});
                    end
                    3: wr_log.push_back(wr_addr);
                    default: ;
                endcase
            end
            if (r[u]) hi_len[u]++;
            else if (prev[u]) begin
                len_log.push_back(hi_len[u]);
                hi_len[u] = 0;
            end
            prev[u] = r[u];
        end
        if (spur_en && data_req && !acked[1] && cnt[1] == 1) begin
            add_done = 1'b1;
            wr_done  = 1'b1;
        end
        for (int u = 0; u < 4; u++) begin
            if (r[u]) begin
                if (!acked[u]) begin
                    if (cnt[u] == lat) begin
                        acked[u] = 1'b1;
                        case (u)
                            0: wgt_done = 1'b1;
                            1: data_done = 1'b1;
                            2: add_done = 1'b1;
                            default: wr_done = 1'b1;
                        endcase
                    end else begin
                        cnt[u]++;
                    end
                end
            end else begin
                cnt[u] = 0;
                acked[u] = 1'b0;
            end
        end
    endtask

    task automatic run_job(input int n, input logic [AW-1:0] wa, input logic [AW-1:0] ia,
                           input logic [AW-1:0] oa, input int l, input bit sp, input int inj_s,
                           output int done_s, output logic busy_s0);
        clear_logs();
        lat = l; spur_en = sp; done_s = -1;
        cfg_num_tiles = CW'(n); cfg_wgt_addr = wa; cfg_in_addr = ia; cfg_out_addr = oa;
        start = 1'b1;
        s_idx = -1;
        step_cycle();
        start = 1'b0;
        busy_s0 = busy;
        while (!done && s_idx < 3000) begin
            if (s_idx == inj_s) begin
                start = 1'b1;
                cfg_num_tiles = CW'(5);
                cfg_in_addr = 32'hDEAD_0000;
                cfg_out_addr = 32'hBEEF_0000;
            end
            step_cycle();
            start = 1'b0;
        end
        if (done) done_s = s_idx;
        for (int k = 0; k < 3; k++) step_cycle();
        spur_en = 1'b0;
    endtask

    task automatic test_reset();
        #1 rstn = 1'b0;
        #11;
        n_checks++;
        if ({busy, done, err, wgt_req, data_req, add_en, wr_req, is_last} !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 00000000",
                     {busy, done, err, wgt_req, data_req, add_en, wr_req, is_last});
        end
        n_checks++;
        if ({wgt_addr, data_addr, wr_addr, tile_idx} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got %h/%h/%h/%h expected all zero",
                     wgt_addr, data_addr, wr_addr, tile_idx);
        end
        n_checks++;
        if (dbg_state !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %0d expected 0", dbg_state);
        end
        reset_model();
        @(negedge clk) rstn = 1'b1;
        clear_logs();
        for (int k = 0; k < 4; k++) step_cycle();
        n_checks++;
        if (req_rises + done_cnt + err_cnt + int'(busy) !== 0) begin
            n_fail++;
            $display("FAIL idle_quiet: got %0d events expected 0", req_rises + done_cnt + err_cnt + int'(busy));
        end
    endtask

    task automatic test_basic();
        int ds;
        logic b0;
        run_job(3, 32'h1000, 32'h2000, 32'h3000, 5, 1'b0, -1, ds, b0);
        n_checks++;
        if (ds !== 72) begin n_fail++; $display("FAIL basic_done_cycle: got %0d expected 72", ds); end
        n_checks++;
        if (b0 !== 1'b1) begin n_fail++; $display("FAIL basic_busy_s0: got %b expected 1", b0); end
        n_checks++;
        if (done_cnt !== 1) begin n_fail++; $display("FAIL basic_done_cnt: got %0d expected 1", done_cnt); end
        n_checks++;
        if (wgt_log.size() !== 1) begin n_fail++; $display("FAIL basic_wgt_cnt: got %0d expected 1", wgt_log.size()); end
        n_checks++;
        if (wgt_log.size() < 1 || wgt_log[0] !== 32'h1000) begin
            n_fail++; $display("FAIL basic_wgt_addr: got %h expected 00001000", wgt_log.size() ? wgt_log[0] : 'x);
        end
        exp_q = '{32'h2000, 32'h2100, 32'h2200};
        n_checks++;
        if (data_log.size() !== 3) begin n_fail++; $display("FAIL basic_data_cnt: got %0d expected 3", data_log.size()); end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (i >= data_log.size() || data_log[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL basic_data_addr[%0d]: got %h expected %h", i, i < data_log.size() ? data_log[i] : 'x, exp_q[i]);
            end
        end
        exp_q = '{32'h3000, 32'h3040, 32'h3080};
        n_checks++;
        if (wr_log.size() !== 3) begin n_fail++; $display("FAIL basic_wr_cnt: got %0d expected 3", wr_log.size()); end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (i >= wr_log.size() || wr_log[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL basic_wr_addr[%0d]: got %h expected %h", i, i < wr_log.size() ? wr_log[i] : 'x, exp_q[i]);
            end
        end
        exp_q = '{32'h0_0000, 32'h0_0001, 32'h1_0002};
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (i >= tile_log.size() || AW'(tile_log[i]) !== exp_q[i]) begin
                n_fail++; $display("FAIL basic_last_idx[%0d]: got %h expected %h", i, i < tile_log.size() ? tile_log[i] : 'x, exp_q[i]);
            end
        end
        n_checks++;
        if (overlap_cnt !== 0) begin n_fail++; $display("FAIL basic_overlap: got %0d expected 0", overlap_cnt); end
        n_checks++;
        if (done_busy_cnt !== 0) begin n_fail++; $display("FAIL basic_done_busy: got %0d expected 0", done_busy_cnt); end
        n_checks++;
        if ({busy, is_last, dbg_state} !== 5'b0) begin
            n_fail++; $display("FAIL basic_end_idle: got %b expected 00000", {busy, is_last, dbg_state});
        end
    endtask

    task automatic test_err();
        clear_logs();
        cfg_num_tiles = '0;
        start = 1'b1;
        s_idx = -1;
        step_cycle();
        start = 1'b0;
        n_checks++;
        if ({err, busy} !== 2'b10) begin n_fail++; $display("FAIL err_pulse: got err,busy=%b expected 10", {err, busy}); end
        step_cycle();
        n_checks++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL err_width: got %b expected 0", err); end
        for (int k = 0; k < 10; k++) step_cycle();
        n_checks++;
        if (err_cnt !== 1) begin n_fail++; $display("FAIL err_cnt: got %0d expected 1", err_cnt); end
        n_checks++;
        if (req_rises + int'(busy) !== 0) begin n_fail++; $display("FAIL err_no_req: got %0d expected 0", req_rises + int'(busy)); end
    endtask

    task automatic test_single_zero_latency();
        int ds;
        logic b0;
        run_job(1, 32'h40, 32'h80, 32'hC0, 0, 1'b0, -1, ds, b0);
        n_checks++;
        if (ds !== 8) begin n_fail++; $display("FAIL single_done_cycle: got %0d expected 8", ds); end
        n_checks++;
        if (len_log.size() !== 4) begin n_fail++; $display("FAIL single_req_cnt: got %0d expected 4", len_log.size()); end
        for (int i = 0; i < len_log.size(); i++) begin
            n_checks++;
            if (len_log[i] !== 1) begin n_fail++; $display("FAIL single_req_len[%0d]: got %0d expected 1", i, len_log[i]); end
        end
        n_checks++;
        if (tile_log.size() < 1 || tile_log[0] !== 17'h1_0000) begin
            n_fail++; $display("FAIL single_is_last: got %h expected 10000", tile_log.size() ? tile_log[0] : 'x);
        end
        n_checks++;
        if ({done_cnt, done_busy_cnt} !== {32'd1, 32'd0}) begin
            n_fail++; $display("FAIL single_done: got cnt=%0d busy_at_done=%0d expected 1/0", done_cnt, done_busy_cnt);
        end
    endtask

    task automatic test_spurious_and_restart();
        int ds;
        logic b0;
        run_job(2, 32'h500, 32'h4000, 32'h6000, 2, 1'b1, 10, ds, b0);
        n_checks++;
        if (ds !== 29) begin n_fail++; $display("FAIL spur_done_cycle: got %0d expected 29", ds); end
        exp_q = '{32'h4000, 32'h4100};
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (i >= data_log.size() || data_log[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL spur_data_addr[%0d]: got %h expected %h", i, i < data_log.size() ? data_log[i] : 'x, exp_q[i]);
            end
        end
        n_checks++;
        if (wr_log.size() < 2 || wr_log[1] !== 32'h6040) begin
            n_fail++; $display("FAIL spur_wr_addr: got %h expected 00006040", wr_log.size() > 1 ? wr_log[1] : 'x);
        end
        n_checks++;
        if ({wgt_log.size(), err_cnt, done_cnt} !== {32'd1, 32'd0, 32'd1}) begin
            n_fail++; $display("FAIL spur_counts: got wgt=%0d err=%0d done=%0d expected 1/0/1", wgt_log.size(), err_cnt, done_cnt);
        end
    endtask

    task automatic test_wrap();
        int ds;
        logic b0;
        run_job(2, 32'h0, 32'hFFFF_FF00, 32'hFFFF_FFC0, 1, 1'b0, -1, ds, b0);
        n_checks++;
        if (ds !== 22) begin n_fail++; $display("FAIL wrap_done_cycle: got %0d expected 22", ds); end
        n_checks++;
        if (data_log.size() < 2 || data_log[1] !== 32'h0000_0000) begin
            n_fail++; $display("FAIL wrap_data_addr: got %h expected 00000000", data_log.size() > 1 ? data_log[1] : 'x);
        end
        n_checks++;
        if (wr_log.size() < 2 || wr_log[1] !== 32'h0000_0000) begin
            n_fail++; $display("FAIL wrap_wr_addr: got %h expected 00000000", wr_log.size() > 1 ? wr_log[1] : 'x);
        end
    endtask

    task automatic test_abort_restart();
        int ds;
        logic b0;
        bit found;
        clear_logs();
        lat = 3;
        cfg_num_tiles = CW'(3); cfg_wgt_addr = 32'h1000; cfg_in_addr = 32'h2000; cfg_out_addr = 32'h3000;
        start = 1'b1;
        s_idx = -1;
        step_cycle();
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 500 && !found; k++) begin
            if (add_en && tile_idx == CW'(1)) found = 1'b1;
            else step_cycle();
        end
        n_checks++;
        if (found !== 1'b1) begin n_fail++; $display("FAIL abort_reach_add: got %b expected 1", found); end
        #2 rstn = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, err, wgt_req, data_req, add_en, wr_req, is_last, dbg_state} !== 11'h0 ||
            {wgt_addr, data_addr, wr_addr, tile_idx} !== '0) begin
            n_fail++; $display("FAIL abort_outputs: got ctrl=%b idx=%h expected all zero",
                               {busy, done, err, wgt_req, data_req, add_en, wr_req, is_last, dbg_state}, tile_idx);
        end
        reset_model();
        @(negedge clk) rstn = 1'b1;
        run_job(2, 32'h1000, 32'h2000, 32'h3000, 3, 1'b0, -1, ds, b0);
        n_checks++;
        if (ds !== 36) begin n_fail++; $display("FAIL abort_rerun_done: got %0d expected 36", ds); end
        exp_q = '{32'h2000, 32'h2100};
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (i >= data_log.size() || data_log[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL abort_rerun_data[%0d]: got %h expected %h", i, i < data_log.size() ? data_log[i] : 'x, exp_q[i]);
            end
        end
        n_checks++;
        if (tile_log.size() < 1 || tile_log[0] !== 17'h0_0000) begin
            n_fail++; $display("FAIL abort_rerun_tile0: got %h expected 00000", tile_log.size() ? tile_log[0] : 'x);
        end
    endtask

    initial begin
        reset_model();
        clear_logs();
        test_reset();
        test_basic();
        test_err();
        test_single_zero_latency();
        test_spurious_and_restart();
        test_wrap();
        test_abort_restart();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
